// File: rtl/block_transfer_pkg.sv
// Shared types, instruction field positions and helpers for the LDM/STM sequencer.
package block_transfer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Encoded as {P, U} so the mode can be cast straight from the instruction bits
  typedef enum logic [1:0] {
    DA = 2'b00,
    IA = 2'b01,
    DB = 2'b10,
    IB = 2'b11
  } addr_mode_t;

  localparam int P_BIT  = 24;
  localparam int U_BIT  = 23;
  localparam int W_BIT  = 21;
  localparam int L_BIT  = 20;
  localparam int RN_MSB = 19;
  localparam int RN_LSB = 16;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/block_transfer_ctl_lowest_set_bit.sv
// 16-bit priority encoder: index of the lowest set bit plus a valid flag.
// Purely combinational, no backpressure.
module lowest_set_bit (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        vld
);

  always_comb begin
    idx = '0;
    vld = |vec;
    // Walk downward so the lowest set bit is the last (winning) assignment
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/block_transfer_ctl.sv
// LDM/STM sequencer: stalls fetch, walks the register list one word per memory beat, then writes back Rn.
// Latency 1 + n + W + 1 cycles after start with zero-wait memory; each beat holds until mem_ready or WAIT_LIMIT.
module block_transfer_ctl
  import block_transfer_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int WORD_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] base_value,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  output logic [3:0]  reg_addr,
  output logic        load_write,
  output logic        base_write,
  output logic [31:0] base_wb_value,
  output logic        pc_written,
  output logic        done,
  output logic        error
);

  localparam int WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

  state_t          state;
  logic            p_q, u_q, w_q, l_q;
  logic [3:0]      rn_q;
  logic [15:0]     list_full;
  logic [15:0]     list_q;
  logic [31:0]     base_q;
  logic [31:0]     wb_hold;
  logic [WCW-1:0]  wait_cnt;

  logic [4:0]      n_regs;
  logic [31:0]     span;
  logic [31:0]     start_addr;
  logic [31:0]     wb_val;
  logic [15:0]     list_rem;
  logic [15:0]     enc_in;
  logic [3:0]      next_reg;
  logic            next_vld;
  addr_mode_t      mode;

  always_comb begin
    mode   = addr_mode_t'({p_q, u_q});
    n_regs = popcount16(list_q);
    span   = 32'(n_regs) * 32'(WORD_BYTES);
    wb_val = u_q ? (base_q + span) : (base_q - span);
    case (mode)
      IA:      start_addr = base_q;
      IB:      start_addr = base_q + 32'(WORD_BYTES);
      DA:      start_addr = base_q - span + 32'(WORD_BYTES);
      default: start_addr = base_q - span;
    endcase
  end

  // In SETUP the encoder sees the whole list; in XFER it sees the list minus the beat in flight
  assign list_rem = list_q & ~(16'(1) << reg_addr);
  assign enc_in   = (state == SETUP) ? list_q : list_rem;

  lowest_set_bit u_lsb (
    .vec (enc_in),
    .idx (next_reg),
    .vld (next_vld)
  );

  assign load_write = mem_req & mem_ready & l_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      p_q           <= 1'b0;
      u_q           <= 1'b0;
      w_q           <= 1'b0;
      l_q           <= 1'b0;
      rn_q          <= '0;
      list_full     <= '0;
      list_q        <= '0;
      base_q        <= '0;
      wb_hold       <= '0;
      wait_cnt      <= '0;
      busy          <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      reg_addr      <= '0;
      base_write    <= 1'b0;
      base_wb_value <= '0;
      pc_written    <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      base_write    <= 1'b0;
      base_wb_value <= '0;
      pc_written    <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            p_q       <= instr[P_BIT];
            u_q       <= instr[U_BIT];
            w_q       <= instr[W_BIT];
            l_q       <= instr[L_BIT];
            rn_q      <= instr[RN_MSB:RN_LSB];
            list_full <= instr[15:0];
            list_q    <= instr[15:0];
            base_q    <= base_value;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end

        SETUP: begin
          wb_hold  <= wb_val;
          wait_cnt <= '0;
          if (list_q == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= ~l_q;
            mem_addr <= word_align(start_addr);
            reg_addr <= next_reg;
            state    <= XFER;
          end
        end

        XFER: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            list_q   <= list_rem;
            if (next_vld) begin
              mem_addr <= word_align(mem_addr + 32'(WORD_BYTES));
              reg_addr <= next_reg;
            end else begin
              mem_req  <= 1'b0;
              mem_we   <= 1'b0;
              mem_addr <= '0;
              reg_addr <= '0;
              if (w_q) begin
                // A load into Rn keeps the loaded value rather than the writeback
                base_write    <= ~(l_q & list_full[rn_q]);
                base_wb_value <= wb_hold;
                state         <= WB;
              end else begin
                done       <= 1'b1;
                pc_written <= l_q & list_full[15];
                state      <= DONE;
              end
            end
          end else if (wait_cnt == WAIT_LAST) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            reg_addr <= '0;
            done     <= 1'b1;
            error    <= 1'b1;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        WB: begin
          done       <= 1'b1;
          pc_written <= l_q & list_full[15];
          state      <= DONE;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_transfer_ctl.sv
// Randomized bench for block_transfer_ctl with a cycle-timeline reference model.
module tb_block_transfer_ctl;

  localparam int WL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instr;
  logic [31:0] base_value;
  logic        busy, mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, base_wb_value;
  logic [3:0]  reg_addr;
  logic        load_write, base_write, pc_written, done, error;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  reg_addr;
    logic        load_write;
    logic        base_write;
    logic [31:0] base_wb_value;
    logic        pc_written;
    logic        done;
    logic        error;
  } obs_t;

  always #5 clk = ~clk;

  block_transfer_ctl #(.WAIT_LIMIT(WL), .WORD_BYTES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .instr         (instr),
    .base_value    (base_value),
    .busy          (busy),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .reg_addr      (reg_addr),
    .load_write    (load_write),
    .base_write    (base_write),
    .base_wb_value (base_wb_value),
    .pc_written    (pc_written),
    .done          (done),
    .error         (error)
  );

  function automatic obs_t sample();
    obs_t o;
    o.busy          = busy;
    o.mem_req       = mem_req;
    o.mem_we        = mem_we;
    o.mem_addr      = mem_addr;
    o.reg_addr      = reg_addr;
    o.load_write    = load_write;
    o.base_write    = base_write;
    o.base_wb_value = base_wb_value;
    o.pc_written    = pc_written;
    o.done          = done;
    o.error         = error;
    return o;
  endfunction

  function automatic logic [31:0] mk_instr(input logic l, p, u, w, input logic [3:0] rn,
                                           input logic [15:0] list);
    return {7'b0, p, u, 1'b0, w, l, rn, list};
  endfunction

  // Builds the expected per-cycle output timeline from the transfer rules, then drives and compares.
  task automatic run_xfer(input string name, input logic l, p, u, w, input logic [3:0] rn,
                          input logic [15:0] list, input logic [31:0] base,
                          input int first_stall, input int max_stall, input bit noisy);
    int          regs[$];
    int          stalls[$];
    obs_t        exp_q[$];
    logic        rdy_q[$];
    obs_t        e, got;
    int          n, beat;
    bit          abort;
    logic [31:0] span, first;

    for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
    n    = regs.size();
    span = 32'(n * 4);
    case ({p, u})
      2'b01:   first = base;
      2'b11:   first = base + 32'd4;
      2'b00:   first = base - span + 32'd4;
      default: first = base - span;
    endcase
    for (int i = 0; i < n; i++)
      stalls.push_back((i == 0 && first_stall >= 0) ? first_stall : int'($urandom_range(max_stall, 0)));

    e = '0; e.busy = 1'b1;
    exp_q.push_back(e); rdy_q.push_back(1'($urandom));
    abort = 1'b0;
    beat  = 0;
    while (beat < n && !abort) begin
      e = '0;
      e.busy     = 1'b1;
      e.mem_req  = 1'b1;
      e.mem_we   = ~l;
      e.mem_addr = (first + 32'(beat * 4)) & 32'hFFFF_FFFC;
      e.reg_addr = 4'(regs[beat]);
      for (int s = 0; s < stalls[beat] && !abort; s++) begin
        exp_q.push_back(e); rdy_q.push_back(1'b0);
        if (s + 1 == WL) abort = 1'b1;
      end
      if (!abort) begin
        e.load_write = l;
        exp_q.push_back(e); rdy_q.push_back(1'b1);
        beat++;
      end
    end
    if (n > 0 && !abort && w) begin
      e = '0;
      e.busy          = 1'b1;
      e.base_write    = ~(l & list[rn]);
      e.base_wb_value = u ? base + span : base - span;
      exp_q.push_back(e); rdy_q.push_back(1'($urandom));
    end
    e = '0;
    e.busy       = 1'b1;
    e.done       = 1'b1;
    e.error      = abort;
    e.pc_written = l & list[15] & ~abort;
    exp_q.push_back(e); rdy_q.push_back(1'($urandom));
    e = '0;
    exp_q.push_back(e); rdy_q.push_back(1'($urandom));

    @(negedge clk);
    start      = 1'b1;
    instr      = mk_instr(l, p, u, w, rn, list);
    base_value = base;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      start     = (noisy && c < exp_q.size() - 2) ? 1'b1 : 1'b0;
      if (noisy) begin
        instr      = $urandom;
        base_value = $urandom;
      end
      mem_ready = rdy_q[c];
      #1;
      got = sample();
      n_tests++;
      if (got !== exp_q[c]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c + 1, got, exp_q[c]);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    instr = mk_instr(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 16'hFFFF);
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      got = sample();
      n_tests++;
      if (got !== obs_t'(0)) begin
        n_fail++;
        $display("FAIL reset_state %0d: got %h expected 0", k, got);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    obs_t got;
    @(negedge clk);
    start      = 1'b1;
    instr      = mk_instr(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 16'h0007);
    base_value = 32'h3000;
    mem_ready  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3004 || reg_addr !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_mid_beat: got req %b addr %h reg %0d expected 1 00003004 1",
               mem_req, mem_addr, reg_addr);
    end
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      got = sample();
      n_tests++;
      if (got !== obs_t'(0)) begin
        n_fail++;
        $display("FAIL reset_mid_after %0d: got %h expected 0", k, got);
      end
      reset = 1'b1;
    end
  endtask

  task automatic test_directed();
    run_xfer("stm_ia",       1'b0, 1'b0, 1'b1, 1'b0, 4'd1,  16'h000E, 32'h1000, 0, 0, 1'b0);
    run_xfer("ldm_db",       1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 16'h8011, 32'h2000, 0, 0, 1'b0);
    run_xfer("ldm_rn_in",    1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  16'h0006, 32'h0800, 0, 0, 1'b0);
    run_xfer("stm_ib_wait",  1'b0, 1'b1, 1'b1, 1'b0, 4'd5,  16'h0001, 32'h4000, 3, 0, 1'b0);
    run_xfer("timeout",      1'b1, 1'b0, 1'b1, 1'b1, 4'd3,  16'h80F0, 32'h5000, 100, 0, 1'b0);
    run_xfer("empty_list",   1'b1, 1'b0, 1'b1, 1'b1, 4'd3,  16'h0000, 32'h6000, 0, 0, 1'b0);
    run_xfer("start_ignored",1'b0, 1'b0, 1'b0, 1'b1, 4'd7,  16'h0C30, 32'h7000, 0, 1, 1'b1);
    run_xfer("wrap_db",      1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  16'h00F0, 32'h0000, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 25; i++) begin
      r = $urandom;
      run_xfer($sformatf("rand%0d", i), r[0], r[1], r[2], r[3], r[7:4],
               16'($urandom), $urandom, -1, 2, r[8]);
    end
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    instr      = '0;
    base_value = '0;
    mem_ready  = 1'b0;
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/block_transfer_ctl.md
Name: block_transfer_ctl

Overview:
Multi-cycle sequencer for ARM load/store-multiple (LDM/STM) instructions on the single-cycle datapath.
- Once a decoded block transfer is accepted, it stalls instruction fetch and walks the register list, one word per memory beat.
- For each beat it drives the register-file address and the memory handshake.
- It finishes with an optional base-register writeback through the datapath's base write port.

Parameters:
WAIT_LIMIT, 255, maximum cycles a beat may wait for mem_ready before the transfer aborts with error.
WORD_BYTES, 4, address increment per transferred register.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
start  input  1  decoded LDM/STM valid; sampled only in IDLE
instr  input  32  instruction: P=24, U=23, S=22 (ignored), W=21, L=20, Rn=19:16, reglist=15:0
base_value  input  32  current Rn value; sampled with start
busy  output  1  stall request to PC/fetch; high in every non-IDLE state
mem_req  output  1  memory beat request
mem_we  output  1  1=store (L=0), 0=load; valid while mem_req
mem_addr  output  32  beat address, bits[1:0] forced 00
mem_ready  input  1  beat accepted/data valid this cycle
reg_addr  output  4  register being transferred (store source / load destination)
load_write  output  1  register-file write enable = mem_req & mem_ready & L
base_write  output  1  one-cycle base-register write enable
base_wb_value  output  32  writeback value for Rn
pc_written  output  1  one-cycle pulse in DONE if a load wrote r15
done  output  1  one-cycle completion pulse
error  output  1  one-cycle pulse in DONE when the transfer aborted on timeout

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE; all outputs 0; internal counters and latched fields cleared. Mid-operation reset abandons the transfer with no further write pulses.
- States: IDLE, SETUP, XFER, WB, DONE.
- IDLE: start=1 latches instr, base_value and reglist, then goes to SETUP. start in any other state is ignored.
- SETUP (1 cycle):
  - n = popcount(reglist).
  - Start address: IA (P0,U1) = Rn; IB (P1,U1) = Rn+4; DA (P0,U0) = Rn-4n+4; DB (P1,U0) = Rn-4n.
  - Writeback value: Rn+4n if U=1, Rn-4n if U=0. All arithmetic is modulo 2^32.
  - n==0: go to DONE (no beats, no writeback). Otherwise go to XFER with cur_reg = lowest set bit.
- XFER:
  - mem_req=1; mem_addr = cur_addr; reg_addr = cur_reg; mem_we = ~L.
  - Registers go in ascending index order to ascending addresses, independent of U.
  - On mem_ready: clear cur_reg in the list, cur_addr += WORD_BYTES, reset wait counter.
  - If the list is now empty, go to WB if W=1, else DONE. Otherwise stay in XFER; the next register is presented the following cycle, so there are no bubble cycles between accepted beats.
  - No mem_ready: wait counter increments. At WAIT_LIMIT, go to DONE with error flagged; no writeback; remaining registers untouched.
- WB (1 cycle): base_write=1 with base_wb_value. Suppressed (base_write=0) when L=1 and Rn is in the list, so the loaded value wins.
- DONE (1 cycle):
  - done=1.
  - pc_written=1 if L=1, bit15 set and no error.
  - error=1 if aborted.
  - Then return to IDLE.
- Latency with a zero-wait memory: 1 (SETUP) + n (XFER) + W (WB) + 1 (DONE) cycles after the start cycle.
- Outputs not named active in a state are 0 in that state.
- mem_addr and reg_addr may change only after an accepted beat.

Decomposition:
- Shared package block_transfer_pkg:
  - state enum (IDLE, SETUP, XFER, WB, DONE);
  - instruction bit-position constants (P_BIT, U_BIT, W_BIT, L_BIT, RN_MSB/LSB);
  - addressing-mode enum (IA, IB, DA, DB).
- One natural sub-module: lowest_set_bit. It is a 16-bit priority encoder that outputs index and a valid flag, and is reused for cur_reg selection.
- popcount stays as a function in the package.

Test Plan:
- STM IA, Rn=r1=0x1000, reglist=0x000E (r1,r2,r3), W=0, mem_ready tied 1 -> beats at 0x1000/0x1004/0x1008 with reg_addr 1/2/3, mem_we=1, no base_write, done 5 cycles after start.
- LDM DB, Rn=r13=0x2000, reglist=0x8011 (r0,r4,r15), W=1 -> addrs 0x1FF4/0x1FF8/0x1FFC, load_write on each beat, base_write with 0x1FF4, pc_written=1 in DONE.
- LDM IA, W=1, Rn=r2 in list (reglist=0x0006) -> two loads, base_write stays 0.
- STM IB, reglist=0x0001, mem_ready low 3 cycles then high -> mem_addr=Rn+4 held stable for 4 cycles, single beat, done follows.
- Timeout: mem_ready never asserts with WAIT_LIMIT=4 -> DONE reached with error=1, no base_write, no load_write; reglist=0 -> done 2 cycles after start, no mem_req.
- Reset asserted (reset=0) during the second XFER beat -> next cycle busy=0, mem_req=0, state IDLE; start during busy ignored; Rn=0x0 with DB wraps to 0xFFFFFFF0 for n=4.
